// File: rtl/player_ctl_if.sv
// Keyboard/vblank inputs and sprite position outputs of the player motion controller.
interface player_ctl_if;
  logic        vblnk;
  logic        key_left;
  logic        key_right;
  logic        key_jump;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic [1:0]  state;
  logic [4:0]  charge;

  modport master (output vblnk, key_left, key_right, key_jump,
                  input  x_value, y_value, state, charge);
  modport slave  (input  vblnk, key_left, key_right, key_jump,
                  output x_value, y_value, state, charge);
endinterface

// File: rtl/player_ctl.sv
// Player sprite motion controller: ground walk, charged jump and gravity flight, one step per vblnk rising edge.
// Define PLAYER_CTL_WALL_BOUNCE_EN to make the sprite rebound off the side walls while airborne.
module player_ctl #(
  parameter int X_INIT     = 400,
  parameter int FLOOR_Y    = 536,
  parameter int X_MAX      = 752,
  parameter int WALK_STEP  = 2,
  parameter int VX_JUMP    = 3,
  parameter int CHARGE_MAX = 31,
  parameter int GRAVITY    = 1,
  parameter int VY_MAX     = 15
) (
  input logic         clk,
  input logic         rst,
  player_ctl_if.slave bus
);
  typedef enum logic [1:0] {GROUND = 2'd0, CHARGE = 2'd1, AIR = 2'd2} state_t;

  localparam logic signed [12:0] FLOOR_S      = 13'(FLOOR_Y);
  localparam logic signed [12:0] X_MAX_S      = 13'(X_MAX);
  localparam logic signed [12:0] STEP_S       = 13'(WALK_STEP);
  localparam logic signed [12:0] VXJ_S        = 13'(VX_JUMP);
  localparam logic signed [12:0] GRAV_S       = 13'(GRAVITY);
  localparam logic signed [12:0] VY_MAX_S     = 13'(VY_MAX);
  localparam logic [4:0]         CHARGE_MAX_U = 5'(CHARGE_MAX);

  state_t             st;
  logic [11:0]        x_q;
  logic [11:0]        y_q;
  logic [4:0]         charge_q;
  logic signed [12:0] vx;
  logic signed [12:0] vy;
  logic signed [12:0] jdir;
  logic               vblnk_d;
  logic               armed;

  logic               tick;
  logic signed [12:0] dir;
  logic signed [12:0] walk_x;
  logic signed [12:0] walk_x_clamped;
  logic signed [12:0] nx;
  logic signed [12:0] ny;
  logic signed [12:0] vy_grav;
  logic signed [12:0] vy_launch;
  logic signed [12:0] wall_vx;
  logic [4:0]         charge_inc;

  always_comb begin
    tick = bus.vblnk & ~vblnk_d;
    dir  = '0;
    if (bus.key_right && !bus.key_left)
      dir = 13'sd1;
    else if (bus.key_left && !bus.key_right)
      dir = -13'sd1;
    walk_x         = $signed({1'b0, x_q}) + dir * STEP_S;
    walk_x_clamped = walk_x;
    if (walk_x < 0)
      walk_x_clamped = '0;
    else if (walk_x > X_MAX_S)
      walk_x_clamped = X_MAX_S;
    nx         = $signed({1'b0, x_q}) + vx;
    ny         = $signed({1'b0, y_q}) + vy;
    vy_grav    = (vy + GRAV_S > VY_MAX_S) ? VY_MAX_S : vy + GRAV_S;
    vy_launch  = -(13'sd4 + $signed({9'd0, charge_q[4:1]}));
    charge_inc = (charge_q >= CHARGE_MAX_U) ? CHARGE_MAX_U : charge_q + 5'd1;
`ifdef PLAYER_CTL_WALL_BOUNCE_EN
    wall_vx = -vx;
`else
    wall_vx = '0;
`endif
  end

  // armed is only updated on ticks, so a jump pressed between frames is still honoured at the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= GROUND;
      x_q      <= 12'(X_INIT);
      y_q      <= 12'(FLOOR_Y);
      charge_q <= '0;
      vx       <= '0;
      vy       <= '0;
      jdir     <= '0;
      vblnk_d  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      vblnk_d <= bus.vblnk;
      if (tick) begin
        armed <= ~bus.key_jump;
        unique case (st)
          GROUND: begin
            if (bus.key_jump && armed) begin
              st       <= CHARGE;
              charge_q <= '0;
              jdir     <= dir;
            end else begin
              x_q <= walk_x_clamped[11:0];
            end
          end
          CHARGE: begin
            if (bus.key_jump) begin
              charge_q <= charge_inc;
              jdir     <= dir;
            end else begin
              st       <= AIR;
              vy       <= vy_launch;
              vx       <= jdir * VXJ_S;
              charge_q <= '0;
            end
          end
          AIR: begin
            vy  <= vy_grav;
            y_q <= ny[11:0];
            x_q <= nx[11:0];
            if (ny < 0) begin
              y_q <= '0;
              vy  <= '0;
            end
            if (nx < 0) begin
              x_q <= '0;
              vx  <= wall_vx;
            end else if (nx > X_MAX_S) begin
              x_q <= X_MAX_S[11:0];
              vx  <= wall_vx;
            end
            // Landing wins over wall handling for vx.
            if (vy > 0 && ny >= FLOOR_S) begin
              y_q <= FLOOR_S[11:0];
              vx  <= '0;
              vy  <= '0;
              st  <= GROUND;
            end
          end
          default: st <= GROUND;
        endcase
      end
    end
  end

  assign bus.x_value = x_q;
  assign bus.y_value = y_q;
  assign bus.state   = st;
  assign bus.charge  = charge_q;
endmodule

// File: tb/tb_player_ctl.sv
// Self-checking bench for player_ctl: directed scenarios plus randomized keys/vblnk against a frame-level model.
module tb_player_ctl;
  logic clk = 1'b0;
  logic rst;
  player_ctl_if bus();

  player_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef PLAYER_CTL_WALL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  typedef struct packed {
    int x;
    int y;
    int st;
    int charge;
    int vx;
    int vy;
    int jdir;
    bit armed;
    bit vd;
  } model_t;

  model_t m;
  int     tests = 0;
  int     fails = 0;
  bit     checking = 1'b0;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.x = 400;
    r.y = 536;
    return r;
  endfunction

  // One clock of the player: nothing moves unless this clock ends a vblnk rising-edge cycle.
  function automatic model_t model_step(model_t s, bit vb, bit l, bit r, bit j);
    model_t n;
    int d;
    int nx;
    int ny;
    n = s;
    n.vd = vb;
    if (!vb || s.vd) return n;
    d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    n.armed = !j;
    if (s.st == 0) begin
      if (j && s.armed) begin
        n.st = 1;
        n.charge = 0;
        n.jdir = d;
      end else begin
        n.x = clampi(s.x + 2 * d, 0, 752);
      end
    end else if (s.st == 1) begin
      if (j) begin
        n.charge = (s.charge + 1 > 31) ? 31 : s.charge + 1;
        n.jdir = d;
      end else begin
        n.st = 2;
        n.vy = -(4 + s.charge / 2);
        n.vx = s.jdir * 3;
        n.charge = 0;
      end
    end else begin
      ny = s.y + s.vy;
      nx = s.x + s.vx;
      n.vy = (s.vy + 1 > 15) ? 15 : s.vy + 1;
      n.y = ny;
      n.x = nx;
      if (ny < 0) begin
        n.y = 0;
        n.vy = 0;
      end
      if (nx < 0 || nx > 752) begin
        n.x = clampi(nx, 0, 752);
        n.vx = BOUNCE ? -s.vx : 0;
      end
      if (s.vy > 0 && ny >= 536) begin
        n.y = 536;
        n.vx = 0;
        n.vy = 0;
        n.st = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= rst ? model_reset() : model_step(m, bus.vblnk, bus.key_left, bus.key_right, bus.key_jump);

  task automatic check_output(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    #1;
    if (checking) begin
      check_output("x_value", {20'd0, bus.x_value}, m.x);
      check_output("y_value", {20'd0, bus.y_value}, m.y);
      check_output("state",   {30'd0, bus.state},   m.st);
      check_output("charge",  {27'd0, bus.charge},  m.charge);
    end
  endtask

  // Holds the keys for a number of frames; each frame is 2 cycles of vblnk high then 3 low.
  task automatic apply_stimulus(input bit l, input bit r, input bit j, input int frames);
    bus.key_left  = l;
    bus.key_right = r;
    bus.key_jump  = j;
    for (int f = 0; f < frames; f++) begin
      bus.vblnk = 1'b1;
      clk_cycle();
      clk_cycle();
      bus.vblnk = 1'b0;
      clk_cycle();
      clk_cycle();
      clk_cycle();
    end
  endtask

  task automatic do_reset(input bit jump_held);
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump  = jump_held;
    bus.vblnk     = 1'b0;
    rst = 1'b1;
    clk_cycle();
    clk_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_landing(input string name);
    for (int i = 0; i < 100 && bus.state != 2'd0; i++)
      apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    check_output(name, {30'd0, bus.state}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.vblnk = 1'b0;
    bus.key_left = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump = 1'b0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    clk_cycle();
    rst = 1'b0;
    clk_cycle();
    check_output("reset_x", {20'd0, bus.x_value}, 400);
    check_output("reset_y", {20'd0, bus.y_value}, 536);
    check_output("reset_state", {30'd0, bus.state}, 0);
    check_output("reset_charge", {27'd0, bus.charge}, 0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 10);
    check_output("walk_right_x", {20'd0, bus.x_value}, 420);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3);
    check_output("both_keys_x", {20'd0, bus.x_value}, 420);
    apply_stimulus(1'b1, 1'b0, 1'b0, 215);
    check_output("walk_left_clamp_x", {20'd0, bus.x_value}, 0);

    do_reset(1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 3);
    check_output("unarmed_state", {30'd0, bus.state}, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1);
    check_output("charge_entry_state", {30'd0, bus.state}, 1);
    check_output("charge_entry_count", {27'd0, bus.charge}, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 40);
    check_output("charge_sat", {27'd0, bus.charge}, 31);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    check_output("launch_state", {30'd0, bus.state}, 2);
    check_output("launch_y", {20'd0, bus.y_value}, 536);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    check_output("first_air_y", {20'd0, bus.y_value}, 517);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    check_output("second_air_y", {20'd0, bus.y_value}, 499);
    wait_landing("land_state");
    check_output("land_y", {20'd0, bus.y_value}, 536);
    check_output("land_x", {20'd0, bus.x_value}, 400);

    do_reset(1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 170);
    check_output("walk_to_740", {20'd0, bus.x_value}, 740);
    apply_stimulus(1'b0, 1'b1, 1'b1, 35);
    check_output("wall_charge", {27'd0, bus.charge}, 31);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 5);
    check_output("wall_contact_x", {20'd0, bus.x_value}, 752);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("after_wall_x", {20'd0, bus.x_value}, BOUNCE ? 749 : 752);
    wait_landing("wall_land_state");

    do_reset(1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 21);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8);
    check_output("midair_y", {20'd0, bus.y_value}, 452);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    check_output("midair_reset_x", {20'd0, bus.x_value}, 400);
    check_output("midair_reset_y", {20'd0, bus.y_value}, 536);
    check_output("midair_reset_state", {30'd0, bus.state}, 0);

    for (int i = 0; i < 6000; i++) begin
      bus.vblnk = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 29) == 0) bus.key_left  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) bus.key_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) bus.key_jump  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 1999) == 0);
      clk_cycle();
    end
    rst = 1'b0;
    clk_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
